// File: rtl/traffic_monitor_if.sv
// ============================================================================
// traffic_monitor_if : lamp lines, clear and status bus of the traffic monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

interface traffic_monitor_if #(
  parameter int CNT_W = 8
);
  logic             green;
  logic             yellow;
  logic             red;
  logic             clear;
  logic [1:0]       phase;
  logic             err;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] dwell;

  modport master (
    output green, yellow, red, clear,
    input  phase, err, err_code, cycle_cnt, dwell
  );

  modport slave (
    input  green, yellow, red, clear,
    output phase, err, err_code, cycle_cnt, dwell
  );
endinterface

`default_nettype wire

// File: rtl/traffic_monitor.sv
// ============================================================================
// traffic_monitor : checks G->Y->R lamp sequence and dwell, flags first error
// Revision: 1.0
// ============================================================================
`default_nettype none

module traffic_monitor #(
  parameter int MAX_DWELL = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  traffic_monitor_if.slave mon
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_G   = 3'd1,
    S_Y   = 3'd2,
    S_R   = 3'd3,
    FAULT = 3'd4
  } state_t;

  logic [2:0]       lamp_q;
  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             err_q;
  logic [2:0]       code_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] dwell_q;

  logic       is_off, is_g, is_y, is_r, is_multi;
  logic       advance, stay;
  logic [2:0] fault;

  assign is_off   = (lamp_q == 3'b000);
  assign is_g     = (lamp_q == 3'b100);
  assign is_y     = (lamp_q == 3'b010);
  assign is_r     = (lamp_q == 3'b001);
  assign is_multi = !(is_off || is_g || is_y || is_r);

  always_comb begin
    fault   = 3'd0;
    advance = 1'b0;
    stay    = 1'b0;
    state_d = state_q;
    phase_d = phase_q;
    if (is_multi) begin
      fault = 3'd1;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_g) begin
            advance = 1'b1;
            state_d = S_G;
            phase_d = 2'b01;
          end else if (!is_off) begin
            fault = 3'd2;
          end
        end
        S_G: begin
          if (is_g) stay = 1'b1;
          else if (is_y) begin
            advance = 1'b1;
            state_d = S_Y;
            phase_d = 2'b10;
          end else if (is_off) fault = 3'd4;
          else fault = 3'd2;
        end
        S_Y: begin
          if (is_y) stay = 1'b1;
          else if (is_r) begin
            advance = 1'b1;
            state_d = S_R;
            phase_d = 2'b11;
          end else if (is_off) fault = 3'd4;
          else fault = 3'd2;
        end
        S_R: begin
          if (is_r) stay = 1'b1;
          else if (is_g) begin
            advance = 1'b1;
            state_d = S_G;
            phase_d = 2'b01;
          end else if (is_off) fault = 3'd4;
          else fault = 3'd2;
        end
        default: ;
      endcase
    end
    // Repeating a phase that already reached its limit is the dwell violation.
    if (stay && (dwell_q == CNT_W'(MAX_DWELL))) fault = 3'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamp_q  <= 3'b000;
      state_q <= IDLE;
      phase_q <= 2'b00;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
      cnt_q   <= '0;
      dwell_q <= '0;
    end else begin
      lamp_q <= {mon.green, mon.yellow, mon.red};
      if (mon.clear) begin
        state_q <= IDLE;
        phase_q <= 2'b00;
        err_q   <= 1'b0;
        code_q  <= 3'd0;
        cnt_q   <= '0;
        dwell_q <= '0;
      end else if (state_q != FAULT) begin
        if (fault != 3'd0) begin
          state_q <= FAULT;
          err_q   <= 1'b1;
          code_q  <= fault;
          dwell_q <= '0;
        end else begin
          state_q <= state_d;
          phase_q <= phase_d;
          if (advance) begin
            dwell_q <= CNT_W'(1);
            if ((state_q == S_R) && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
          end else if (stay) begin
            dwell_q <= dwell_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign mon.phase     = phase_q;
  assign mon.err       = err_q;
  assign mon.err_code  = code_q;
  assign mon.cycle_cnt = cnt_q;
  assign mon.dwell     = dwell_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_monitor.sv
// ============================================================================
// tb_traffic_monitor : three monitor configurations on one lamp stimulus
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_traffic_monitor;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] LG  = 3'b100;
  localparam logic [2:0] LY  = 3'b010;
  localparam logic [2:0] LR  = 3'b001;

  logic       clk;
  logic       rst;
  logic [2:0] lamp;
  logic       clear;
  int         checks;
  int         errors;

  // A: MAX_DWELL=1, B: MAX_DWELL=3, C: MAX_DWELL=1 with a 2-bit counter
  traffic_monitor_if #(.CNT_W(8)) ifa ();
  traffic_monitor_if #(.CNT_W(8)) ifb ();
  traffic_monitor_if #(.CNT_W(2)) ifc ();

  assign ifa.green = lamp[2];  assign ifa.yellow = lamp[1];
  assign ifa.red   = lamp[0];  assign ifa.clear  = clear;
  assign ifb.green = lamp[2];  assign ifb.yellow = lamp[1];
  assign ifb.red   = lamp[0];  assign ifb.clear  = clear;
  assign ifc.green = lamp[2];  assign ifc.yellow = lamp[1];
  assign ifc.red   = lamp[0];  assign ifc.clear  = clear;

  traffic_monitor #(.MAX_DWELL(1), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .mon(ifa));
  traffic_monitor #(.MAX_DWELL(3), .CNT_W(8)) u_b (.clk(clk), .rst(rst), .mon(ifb));
  traffic_monitor #(.MAX_DWELL(1), .CNT_W(2)) u_c (.clk(clk), .rst(rst), .mon(ifc));

  always #5 clk = ~clk;

  // Model: cur is the lit phase number (0 none, 1 G, 2 Y, 3 R); legal successor is cur%3+1.
  typedef struct packed {
    logic [2:0] lq;
    int         cur;
    int         dw;
    int         cnt;
    logic       err;
    int         code;
  } m_t;

  m_t m [3];

  function automatic m_t mstep(m_t s, logic [2:0] lin, logic clr, int maxd, int cmax);
    m_t n;
    int p;
    int c;
    n    = s;
    n.lq = lin;
    if (clr) begin
      n.cur = 0; n.dw = 0; n.cnt = 0; n.err = 1'b0; n.code = 0;
      return n;
    end
    if (s.err) return n;
    case (s.lq)
      3'b000:  p = 0;
      3'b100:  p = 1;
      3'b010:  p = 2;
      3'b001:  p = 3;
      default: p = -1;
    endcase
    c = 0;
    if (p < 0) c = 1;
    else if (s.cur == 0) begin
      if (p == 1) begin n.cur = 1; n.dw = 1; end
      else if (p != 0) c = 2;
    end else if (p == s.cur) begin
      if (s.dw == maxd) c = 3;
      else n.dw = s.dw + 1;
    end else if (p == 0) c = 4;
    else if (p == (s.cur % 3) + 1) begin
      n.cur = p;
      n.dw  = 1;
      if (p == 1 && s.cnt < cmax) n.cnt = s.cnt + 1;
    end else c = 2;
    if (c != 0) begin
      n.err = 1'b1; n.code = c; n.dw = 0; n.cur = s.cur; n.cnt = s.cnt;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) m[i] <= '0;
    end else begin
      m[0] <= mstep(m[0], lamp, clear, 1, 255);
      m[1] <= mstep(m[1], lamp, clear, 3, 255);
      m[2] <= mstep(m[2], lamp, clear, 1, 3);
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(string nm, logic [1:0] ph, logic e, logic [2:0] ec, int cc, int dw, m_t s);
    chk({nm, ".phase"},     int'(ph), s.cur);
    chk({nm, ".err"},       int'(e),  int'(s.err));
    chk({nm, ".err_code"},  int'(ec), s.code);
    chk({nm, ".cycle_cnt"}, cc,       s.cnt);
    chk({nm, ".dwell"},     dw,       s.dw);
  endtask

  task automatic compare_all();
    if (!rst) begin
      cmp("A", ifa.phase, ifa.err, ifa.err_code, int'(ifa.cycle_cnt), int'(ifa.dwell), m[0]);
      cmp("B", ifb.phase, ifb.err, ifb.err_code, int'(ifb.cycle_cnt), int'(ifb.dwell), m[1]);
      cmp("C", ifc.phase, ifc.err, ifc.err_code, int'(ifc.cycle_cnt), int'(ifc.dwell), m[2]);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick(logic [2:0] l, logic clr = 1'b0);
    step();
    lamp  = l;
    clear = clr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    lamp  = OFF;
    clear = 1'b0;
    @(negedge clk);
    rst   = 1'b0;
  endtask

  task automatic all_zero(string tag);
    chk({tag, " A.phase"}, int'(ifa.phase), 0);
    chk({tag, " A.err"},   int'(ifa.err), 0);
    chk({tag, " A.code"},  int'(ifa.err_code), 0);
    chk({tag, " A.cnt"},   int'(ifa.cycle_cnt), 0);
    chk({tag, " A.dwell"}, int'(ifa.dwell), 0);
    chk({tag, " B.cnt"},   int'(ifb.cycle_cnt), 0);
    chk({tag, " C.cnt"},   int'(ifc.cycle_cnt), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    clk = 1'b0; rst = 1'b1; lamp = OFF; clear = 1'b0;
    checks = 0; errors = 0;
    #2;
    all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Legal run: outputs trail the lamps by two clocks
    tick(OFF); tick(LG); tick(LY); tick(LR);
    chk("legal A.phase G", int'(ifa.phase), 1);
    chk("legal A.dwell G", int'(ifa.dwell), 1);
    tick(LG);
    chk("legal A.phase Y", int'(ifa.phase), 2);
    tick(LY); tick(LR); tick(LG);
    step(); step();
    chk("legal A.cnt", int'(ifa.cycle_cnt), 2);
    chk("legal A.phase", int'(ifa.phase), 1);
    chk("legal A.err", int'(ifa.err), 0);

    // Illegal skip G->R, then legal lamps must not disturb the first error
    do_reset();
    tick(OFF); tick(LG); tick(LR); step(); step();
    chk("skip A.err", int'(ifa.err), 1);
    chk("skip A.code", int'(ifa.err_code), 2);
    chk("skip A.phase", int'(ifa.phase), 1);
    tick(LY); tick(LR); tick(LG); step(); step();
    chk("skip sticky A.code", int'(ifa.err_code), 2);
    chk("skip sticky C.err", int'(ifc.err), 1);

    // Dwell exceeded on B: G held four clocks
    do_reset();
    tick(OFF); tick(LG); step(); step();
    chk("dwell B=1", int'(ifb.dwell), 1);
    step();
    chk("dwell B=2", int'(ifb.dwell), 2);
    chk("dwell A.code", int'(ifa.err_code), 3);
    tick(LY);
    chk("dwell B=3", int'(ifb.dwell), 3);
    step();
    chk("dwell B.err", int'(ifb.err), 1);
    chk("dwell B.code", int'(ifb.err_code), 3);
    chk("dwell B.dwell0", int'(ifb.dwell), 0);

    // G held three clocks on B is legal
    do_reset();
    tick(OFF); tick(LG); step(); step(); tick(LY); step();
    chk("dwell3 B.dwell", int'(ifb.dwell), 3);
    step();
    chk("dwell3 B.phase", int'(ifb.phase), 2);
    chk("dwell3 B.err", int'(ifb.err), 0);

    // Multi-hot in S_Y outranks illegal transition; clear recovers
    do_reset();
    tick(OFF); tick(LG); tick(LY); tick(3'b011); step(); step();
    chk("multi B.code", int'(ifb.err_code), 1);
    chk("multi B.phase", int'(ifb.phase), 2);
    tick(OFF, 1'b1);
    tick(LG);
    chk("clear B.err", int'(ifb.err), 0);
    chk("clear B.phase", int'(ifb.phase), 0);
    step(); step();
    chk("clear B.accept G", int'(ifb.phase), 1);
    chk("clear B.err2", int'(ifb.err), 0);

    // Dark after start
    do_reset();
    tick(OFF); tick(LG); tick(LY); tick(OFF); step(); step();
    chk("dark B.code", int'(ifb.err_code), 4);
    chk("dark B.phase", int'(ifb.phase), 2);
    do_reset();
    for (int i = 0; i < 20; i++) step();
    chk("idle A.err", int'(ifa.err), 0);
    chk("idle A.phase", int'(ifa.phase), 0);

    // Counter saturation on C, then async reset between edges
    do_reset();
    tick(OFF);
    for (int i = 0; i < 5; i++) begin
      tick(LG); tick(LY); tick(LR);
    end
    tick(LG); step(); step();
    chk("sat C.cnt", int'(ifc.cycle_cnt), 3);
    chk("sat A.cnt", int'(ifa.cycle_cnt), 5);
    chk("sat C.err", int'(ifc.err), 0);
    #2;
    rst  = 1'b1;
    lamp = LR;
    #1;
    all_zero("async");
    #1;
    rst = 1'b0;
    step(); step();
    chk("restart A.code", int'(ifa.err_code), 2);
    chk("restart C.err", int'(ifc.err), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
